// File: rtl/bridge_arbiter_pkg.sv
// Shared types and defaults for the two-master bridge arbiter.
// Holds FSM encoding, window defaults, master indices and the window-hit helper.
package bridge_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [31:0] DEV0_BASE_DEF = 32'h0000_7f00;
    localparam logic [31:0] DEV1_BASE_DEF = 32'h0000_7f10;
    localparam logic [31:0] WIN_LAST_DEF  = 32'h0000_000b;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    // Inclusive window test; subtract after the lower-bound check to avoid wrap.
    function automatic logic in_win(
        input logic [31:0] a,
        input logic [31:0] base,
        input logic [31:0] last
    );
        return (a >= base) && ((a - base) <= last);
    endfunction

endpackage

// File: rtl/bridge_arbiter_if.sv
// Master-request and bridge-side signal bundle for bridge_arbiter.
// slave modport is the arbiter's view; master modport is the requester/bridge view.
interface bridge_arbiter_if;

    logic        ARB_i_M0_Req;
    logic [31:0] ARB_i_M0_Addr;
    logic [31:0] ARB_i_M0_WData;
    logic [3:0]  ARB_i_M0_ByteEnable;
    logic        ARB_i_M0_WEnable;
    logic        ARB_i_M1_Req;
    logic [31:0] ARB_i_M1_Addr;
    logic [31:0] ARB_i_M1_WData;
    logic [3:0]  ARB_i_M1_ByteEnable;
    logic        ARB_i_M1_WEnable;
    logic        ARB_o_M0_Ack;
    logic        ARB_o_M1_Ack;
    logic        ARB_o_Err;
    logic [31:0] ARB_o_RData;
    logic [31:0] ARB_o_BRG_Addr;
    logic [31:0] ARB_o_BRG_WData;
    logic [3:0]  ARB_o_BRG_ByteEnable;
    logic        ARB_o_BRG_WEnable;
    logic [31:0] ARB_i_BRG_RData;

    modport slave (
        input  ARB_i_M0_Req, ARB_i_M0_Addr, ARB_i_M0_WData,
        input  ARB_i_M0_ByteEnable, ARB_i_M0_WEnable,
        input  ARB_i_M1_Req, ARB_i_M1_Addr, ARB_i_M1_WData,
        input  ARB_i_M1_ByteEnable, ARB_i_M1_WEnable,
        input  ARB_i_BRG_RData,
        output ARB_o_M0_Ack, ARB_o_M1_Ack, ARB_o_Err, ARB_o_RData,
        output ARB_o_BRG_Addr, ARB_o_BRG_WData,
        output ARB_o_BRG_ByteEnable, ARB_o_BRG_WEnable
    );

    modport master (
        output ARB_i_M0_Req, ARB_i_M0_Addr, ARB_i_M0_WData,
        output ARB_i_M0_ByteEnable, ARB_i_M0_WEnable,
        output ARB_i_M1_Req, ARB_i_M1_Addr, ARB_i_M1_WData,
        output ARB_i_M1_ByteEnable, ARB_i_M1_WEnable,
        output ARB_i_BRG_RData,
        input  ARB_o_M0_Ack, ARB_o_M1_Ack, ARB_o_Err, ARB_o_RData,
        input  ARB_o_BRG_Addr, ARB_o_BRG_WData,
        input  ARB_o_BRG_ByteEnable, ARB_o_BRG_WEnable
    );

endinterface

// File: rtl/bridge_arbiter_arb_rr2.sv
// Two-way round-robin picker with its last-grant register.
// BRIDGE_ARBITER_FIXED_PRIO_EN: ties always go to M0 and the register is removed.
module arb_rr2
    import bridge_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);

`ifdef BRIDGE_ARBITER_FIXED_PRIO_EN
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, grant_en};

    always_comb begin
        gnt = 2'b00;
        if (req[0]) gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
    end
`else
    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == MST_M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (grant_en && (|req)) last_d = gnt[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= MST_M1;
        else        last_q <= last_d;
    end
`endif

endmodule

// File: rtl/bridge_arbiter.sv
// Two-master to single-bridge arbiter with fixed IDLE/ACCESS/RESP timing.
// Optional build macro: BRIDGE_ARBITER_FIXED_PRIO_EN (fixed M0 priority).
module bridge_arbiter
    import bridge_arbiter_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
    parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF,
    parameter logic [31:0] WIN_LAST  = WIN_LAST_DEF
) (
    input  logic             ARB_i_clk,
    input  logic             ARB_i_rst_n,
    bridge_arbiter_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic        hit_q, hit_d;
    logic        win_q, win_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        grant_en;
    logic [31:0] sel_addr;

    assign req      = {bus.ARB_i_M1_Req, bus.ARB_i_M0_Req};
    assign grant_en = (state_q == ST_IDLE) && (|req);
    assign sel_addr = gnt[1] ? bus.ARB_i_M1_Addr : bus.ARB_i_M0_Addr;

    arb_rr2 u_arb (
        .clk      (ARB_i_clk),
        .rst_n    (ARB_i_rst_n),
        .req      (req),
        .grant_en (grant_en),
        .gnt      (gnt)
    );

    always_ff @(posedge ARB_i_clk or negedge ARB_i_rst_n) begin
        if (!ARB_i_rst_n) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (|req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        hit_d   = hit_q;
        win_d   = win_q;
        rdata_d = rdata_q;
        if (grant_en) begin
            win_d   = gnt[1];
            addr_d  = sel_addr;
            wdata_d = gnt[1] ? bus.ARB_i_M1_WData : bus.ARB_i_M0_WData;
            be_d    = gnt[1] ? bus.ARB_i_M1_ByteEnable : bus.ARB_i_M0_ByteEnable;
            we_d    = gnt[1] ? bus.ARB_i_M1_WEnable : bus.ARB_i_M0_WEnable;
            hit_d   = in_win(sel_addr, DEV0_BASE, WIN_LAST) ||
                      in_win(sel_addr, DEV1_BASE, WIN_LAST);
        end
        if (state_q == ST_ACCESS) begin
            rdata_d = (hit_q && !we_q) ? bus.ARB_i_BRG_RData : 32'h0;
        end
    end

    always_ff @(posedge ARB_i_clk or negedge ARB_i_rst_n) begin
        if (!ARB_i_rst_n) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            win_q   <= MST_M0;
            rdata_q <= 32'h0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            win_q   <= win_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode from state only, so async reset clears them at once.
    always_comb begin
        bus.ARB_o_BRG_Addr       = 32'h0;
        bus.ARB_o_BRG_WData      = 32'h0;
        bus.ARB_o_BRG_ByteEnable = 4'h0;
        bus.ARB_o_BRG_WEnable    = 1'b0;
        bus.ARB_o_M0_Ack         = 1'b0;
        bus.ARB_o_M1_Ack         = 1'b0;
        bus.ARB_o_Err            = 1'b0;
        bus.ARB_o_RData          = 32'h0;
        if (state_q == ST_ACCESS) begin
            bus.ARB_o_BRG_Addr       = addr_q;
            bus.ARB_o_BRG_WData      = wdata_q;
            bus.ARB_o_BRG_ByteEnable = be_q;
            bus.ARB_o_BRG_WEnable    = we_q && hit_q;
        end
        if (state_q == ST_RESP) begin
            bus.ARB_o_M0_Ack = (win_q == MST_M0);
            bus.ARB_o_M1_Ack = (win_q == MST_M1);
            bus.ARB_o_Err    = !hit_q;
            bus.ARB_o_RData  = rdata_q;
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter: vector table, round-robin and reset sequences.
// Expected completions go through a scoreboard queue popped on each Ack.
module tb_bridge_arbiter;
    import bridge_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bridge_arbiter_if bus();

    bridge_arbiter dut (
        .ARB_i_clk   (clk),
        .ARB_i_rst_n (rst_n),
        .bus         (bus)
    );

    typedef struct {
        logic        mst;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] brg_rd;
        logic        exp_bwe;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic        mst;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[10];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_sample();
        logic a0, a1;
        exp_t e;
        a0 = bus.ARB_o_M0_Ack;
        a1 = bus.ARB_o_M1_Ack;
        if (a0 || a1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {30'b0, a1, a0}, 32'h0);
            end else begin
                e = sbq.pop_front();
                chk("ack_sel", {30'b0, a1, a0}, e.mst ? 32'h2 : 32'h1);
                chk("ack_err", {31'b0, bus.ARB_o_Err}, {31'b0, e.err});
                chk("ack_rdata", bus.ARB_o_RData, e.rd);
            end
        end else begin
            chk("quiet_err", {31'b0, bus.ARB_o_Err}, 32'h0);
            chk("quiet_rdata", bus.ARB_o_RData, 32'h0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
    endtask

    task automatic set_m(input logic m, input logic r, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] be, input logic we);
        if (!m) begin
            bus.ARB_i_M0_Req        = r;
            bus.ARB_i_M0_Addr       = a;
            bus.ARB_i_M0_WData      = w;
            bus.ARB_i_M0_ByteEnable = be;
            bus.ARB_i_M0_WEnable    = we;
        end else begin
            bus.ARB_i_M1_Req        = r;
            bus.ARB_i_M1_Addr       = a;
            bus.ARB_i_M1_WData      = w;
            bus.ARB_i_M1_ByteEnable = be;
            bus.ARB_i_M1_WEnable    = we;
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 4 && sbq.size() != 0; k++) tick();
        if (sbq.size() != 0) begin
            chk(name, sbq.size(), 32'h0);
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_m;
        vec_t v;

        vt[0] = '{1'b0, 32'h7f04, 32'h1234_5678, 4'hf, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};
        vt[1] = '{1'b1, 32'h7f10, 32'h0,         4'hf, 1'b0, 32'hdead_beef, 1'b0, 1'b0, 32'hdead_beef};
        vt[2] = '{1'b0, 32'h7f0c, 32'hffff_0000, 4'hf, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0};
        vt[3] = '{1'b0, 32'h7f1b, 32'h0,         4'h8, 1'b0, 32'ha5a5_a5a5, 1'b0, 1'b0, 32'ha5a5_a5a5};
        vt[4] = '{1'b1, 32'h7f0b, 32'h0,         4'h8, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 32'h1111_2222};
        vt[5] = '{1'b1, 32'h7f0c, 32'h0,         4'hf, 1'b0, 32'h3333_4444, 1'b0, 1'b1, 32'h0};
        vt[6] = '{1'b0, 32'h7eff, 32'h0,         4'h1, 1'b0, 32'h5555_6666, 1'b0, 1'b1, 32'h0};
        vt[7] = '{1'b1, 32'h7f1c, 32'h0000_abcd, 4'h3, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0};
        vt[8] = '{1'b1, 32'h7f18, 32'hcafe_f00d, 4'hc, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};
        vt[9] = '{1'b0, 32'h0,    32'h0,         4'hf, 1'b0, 32'h7777_8888, 1'b0, 1'b1, 32'h0};

        set_m(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_m(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        bus.ARB_i_BRG_RData = 32'h0;

        #1;
        chk("rst_m0_ack", {31'b0, bus.ARB_o_M0_Ack}, 32'h0);
        chk("rst_m1_ack", {31'b0, bus.ARB_o_M1_Ack}, 32'h0);
        chk("rst_err", {31'b0, bus.ARB_o_Err}, 32'h0);
        chk("rst_rdata", bus.ARB_o_RData, 32'h0);
        chk("rst_brg_we", {31'b0, bus.ARB_o_BRG_WEnable}, 32'h0);
        chk("rst_brg_addr", bus.ARB_o_BRG_Addr, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            v = vt[i];
            set_m(v.mst, 1'b1, v.addr, v.wdata, v.be, v.we);
            bus.ARB_i_BRG_RData = v.brg_rd;
            sbq.push_back('{v.mst, v.exp_err, v.exp_rd});
            tick();
            chk("acc_brg_we", {31'b0, bus.ARB_o_BRG_WEnable}, {31'b0, v.exp_bwe});
            chk("acc_brg_addr", bus.ARB_o_BRG_Addr, v.addr);
            chk("acc_brg_wdata", bus.ARB_o_BRG_WData, v.wdata);
            chk("acc_brg_be", {28'b0, bus.ARB_o_BRG_ByteEnable}, {28'b0, v.be});
            tick();
            chk("vec_latency", sbq.size(), 32'h0);
            drain("vec_ack_timeout");
            set_m(v.mst, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
            tick();
            chk("idle_brg_we", {31'b0, bus.ARB_o_BRG_WEnable}, 32'h0);
            chk("idle_brg_addr", bus.ARB_o_BRG_Addr, 32'h0);
        end

        // Both masters held from reset: alternating grants, three cycles apart.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_m(1'b0, 1'b1, 32'h7f00, 32'h0, 4'hf, 1'b0);
        set_m(1'b1, 1'b1, 32'h7f14, 32'h0, 4'hf, 1'b0);
        bus.ARB_i_BRG_RData = 32'h0bad_f00d;
        for (int k = 0; k < 3; k++) begin
`ifdef BRIDGE_ARBITER_FIXED_PRIO_EN
            exp_m = 1'b0;
`else
            exp_m = (k == 1) ? 1'b1 : 1'b0;
`endif
            sbq.push_back('{exp_m, 1'b0, 32'h0bad_f00d});
        end
        for (int k = 0; k < 3; k++) begin
            exp_m = sbq[0].mst;
            tick();
            chk("rr_brg_addr", bus.ARB_o_BRG_Addr, exp_m ? 32'h7f14 : 32'h7f00);
            tick();
            chk("rr_latency", sbq.size(), 32'(2 - k));
            if (k == 2) begin
                set_m(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
                set_m(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
            end
            tick();
        end
        drain("rr_ack_timeout");
        tick();
        tick();

        // Reset mid-ACCESS of a write: WEnable drops at once, no Ack, then retry.
        set_m(1'b0, 1'b1, 32'h7f08, 32'h5555_aaaa, 4'hf, 1'b1);
        bus.ARB_i_BRG_RData = 32'h0;
        tick();
        chk("pre_rst_brg_we", {31'b0, bus.ARB_o_BRG_WEnable}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_brg_we", {31'b0, bus.ARB_o_BRG_WEnable}, 32'h0);
        chk("async_brg_addr", bus.ARB_o_BRG_Addr, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        sbq.push_back('{1'b0, 1'b0, 32'h0});
        tick();
        chk("retry_brg_we", {31'b0, bus.ARB_o_BRG_WEnable}, 32'h1);
        chk("retry_brg_addr", bus.ARB_o_BRG_Addr, 32'h7f08);
        tick();
        chk("retry_latency", sbq.size(), 32'h0);
        drain("retry_ack_timeout");
        set_m(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bridge_arbiter.md
BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 Parameter DEV0_BASE, 32'h0000_7f00, first byte address of device-0 window.
REQ-002 Parameter DEV1_BASE, 32'h0000_7f10, first byte address of device-1 window.
REQ-003 Parameter WIN_LAST, 32'h0000_000b, offset of last valid byte in each window.
REQ-004 ARB_i_clk  in  1  sole clock; all state on rising edge.
REQ-005 ARB_i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ARB_i_M0_Req / ARB_i_M1_Req  in  1 each  access request, held until matching Ack.
REQ-007 ARB_i_M0_Addr / ARB_i_M1_Addr  in  32 each  byte address.
REQ-008 ARB_i_M0_WData / ARB_i_M1_WData  in  32 each  write data, already byte-lane shifted.
REQ-009 ARB_i_M0_ByteEnable / ARB_i_M1_ByteEnable  in  4 each  byte lanes.
REQ-010 ARB_i_M0_WEnable / ARB_i_M1_WEnable  in  1 each  1 = write, 0 = read.
REQ-011 ARB_o_M0_Ack / ARB_o_M1_Ack  out  1 each  one-cycle completion pulse.
REQ-012 ARB_o_Err  out  1  valid with Ack; 1 = address outside both windows.
REQ-013 ARB_o_RData  out  32  read data, valid with Ack.
REQ-014 ARB_o_BRG_Addr / ARB_o_BRG_WData  out  32 each  to bridge.
REQ-015 ARB_o_BRG_ByteEnable  out  4  to bridge.
REQ-016 ARB_o_BRG_WEnable  out  1  to bridge.
REQ-017 ARB_i_BRG_RData  in  32  bridge read data, combinational from ARB_o_BRG_Addr.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; IDLE→ACCESS when any Req=1; ACCESS→RESP unconditionally; RESP→IDLE unconditionally.
REQ-019 In IDLE the arbiter SHALL pick a winner, latch its Addr/WData/ByteEnable/WEnable, and latch hit = address in [DEV0_BASE, DEV0_BASE+WIN_LAST] or [DEV1_BASE, DEV1_BASE+WIN_LAST].
REQ-020 Arbitration: single requester wins; both requesting → requester not granted last (round-robin); last-grant register updates on each grant.
REQ-021 In ACCESS, ARB_o_BRG_* SHALL carry latched fields; ARB_o_BRG_WEnable = latched WEnable AND hit, asserted for exactly one cycle.
REQ-022 At end of ACCESS, ARB_i_BRG_RData SHALL be captured when hit and read; otherwise capture 32'h0.
REQ-023 In RESP, winner's Ack = 1 for exactly one cycle, ARB_o_Err = !hit, ARB_o_RData = captured value; other Ack = 0.
REQ-024 Latency fixed: Req sampled in IDLE cycle N → Ack in cycle N+2; next grant no earlier than N+3.
REQ-025 Outside ACCESS, ARB_o_BRG_WEnable = 0 and ARB_o_BRG_Addr/WData/ByteEnable = 0.
REQ-026 Outside RESP, both Acks, ARB_o_Err and ARB_o_RData = 0.
REQ-027 Req changes after grant SHALL be ignored until IDLE; Req still high in IDLE after its Ack is a new request.
REQ-028 Window boundaries inclusive: DEV0_BASE+WIN_LAST hits; DEV0_BASE+WIN_LAST+1 misses.

Reset
REQ-029 ARB_i_rst_n low SHALL immediately force IDLE, all outputs 0, latched fields 0, last-grant = M1 (M0 wins first tie).
REQ-030 Reset during ACCESS SHALL drop ARB_o_BRG_WEnable the same instant; aborted transaction is never acknowledged.

Configuration
REQ-031 Macro BRIDGE_ARBITER_FIXED_PRIO_EN defined: ties always go to M0, last-grant register absent; undefined: round-robin per REQ-020.

Structure
REQ-032 Shared package SHALL hold FSM state encoding, DEV0_BASE/DEV1_BASE/WIN_LAST defaults, master index constants.
REQ-033 Sub-module arb_rr2 (two-way round-robin picker incl. last-grant register) SHALL hold arbitration; FSM and datapath stay in bridge_arbiter.

Verification
REQ-034 M0 write Addr=32'h7f04, WData=32'h1234_5678, BE=4'hf → BRG_WEnable=1 one cycle at N+1 with that addr/data; M0_Ack=1, Err=0 at N+2.
REQ-035 M1 read Addr=32'h7f10, BRG_RData=32'hdead_beef → M1_Ack at N+2 with RData=32'hdead_beef, Err=0.
REQ-036 M0 and M1 request together from reset, both held → grants M0, M1, M0 at N, N+3, N+6; with BRIDGE_ARBITER_FIXED_PRIO_EN all go to M0.
REQ-037 M0 write Addr=32'h7f0c → BRG_WEnable never 1; M0_Ack with Err=1, RData=0; Addr=32'h7f1b read → Err=0.
REQ-038 rst_n low mid-ACCESS of a write → BRG_WEnable falls asynchronously, no Ack; after release, held Req completes normally in 2 cycles.
